// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  // Default operand/result width.
  localparam int W_DEFAULT = 8;

  // Controller states: wait for operands, shift one bit per clock, hold result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : sub_pkg

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: the half subtractor extended with a borrow-in.
// Computes a - b - bin, giving the difference bit and the borrow-out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Difference is the parity of all three inputs.
  assign diff = a ^ b ^ bin;

  // Borrow when b exceeds a, or when a equals b and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_sub_cell

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor computing a_in - b_in, LSB first, one bit per
// clock. Operands enter on a valid/ready handshake, the difference and final
// borrow leave on another. All outputs are decoded from registered state.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff_out,
  output logic         borrow_out,
  output logic         busy
);

  // Bit counter width follows from W; it is not meant to be overridden.
  localparam int              CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic           brw;
  logic [W-1:0]   a_sr;
  logic [W-1:0]   b_sr;
  logic [W-1:0]   d_sr;
  logic           cell_d;
  logic           cell_bout;

  // The single arithmetic cell sees the current LSBs and the stored borrow.
  full_sub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .diff (cell_d),
    .bout (cell_bout)
  );

  // Controller, bit counter, operand/result shift registers and borrow flop.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them update from the
    // values sampled at the same edge; blocking = would let a later line
    // see an already-updated shift register.
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      // NOTE: the shift registers are cleared too, so diff_out can never
      // expose stale or X data, even though a load overwrites them anyway.
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            d_sr  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= {1'b0, a_sr[W-1:1]};
          b_sr <= {1'b0, b_sr[W-1:1]};
          d_sr <= {cell_d, d_sr[W-1:1]};
          brw  <= cell_bout;
          cnt  <= cnt + 1'b1;
          // This edge processed the MSB; the result is complete.
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and result outputs, gated so nothing leaks outside DONE.
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign diff_out   = out_valid ? d_sr : '0;
  assign borrow_out = out_valid & brw;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=8). Expected results come from
// a (W+1)-bit reference subtraction pushed to a scoreboard queue at accept
// time and popped when the result handshake completes.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff_out;
  logic         borrow_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [W:0] sb[$];

  serial_subtractor #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff_out   (diff_out),
    .borrow_out (borrow_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full operation. Called at a negedge with the DUT in IDLE; returns at
  // the negedge one cycle after the result handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit rand_ready, input string tag);
    int         lat;
    int         guard;
    bit         done;
    logic [W:0] exp;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    guard    = 0;
    while (!in_ready && guard < 4 * W) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL %s accept: in_ready=%b required 1", tag, in_ready);
      errors++;
      in_valid = 1'b0;
      return;
    end
    sb.push_back({1'b0, a} - {1'b0, b});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    lat      = 0;
    while (!out_valid && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != W) begin
      $display("FAIL %s latency: got %0d cycles required %0d", tag, lat, W);
      errors++;
    end
    if (!out_valid) begin
      sb.delete();
      return;
    end
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      exp = sb[0];
      checks++;
      if ({out_valid, in_ready, borrow_out, diff_out} !== {2'b10, exp}) begin
        $display("FAIL %s result: valid=%b ready=%b borrow=%b diff=%h required valid=1 ready=0 borrow=%b diff=%h",
                 tag, out_valid, in_ready, borrow_out, diff_out, exp[W], exp[W-1:0]);
        errors++;
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      @(negedge clk);
      done = out_ready;
      guard++;
    end
    if (sb.size() > 0) void'(sb.pop_front());
    checks++;
    if (!done || {out_valid, in_ready, busy, borrow_out, diff_out} !== {3'b010, 1'b0, W'(0)}) begin
      $display("FAIL %s handoff: done=%b valid=%b ready=%b busy=%b borrow=%b diff=%h required done=1 valid=0 ready=1 busy=0 borrow=0 diff=00",
               tag, done, out_valid, in_ready, busy, borrow_out, diff_out);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a_in      = 8'h12;
    b_in      = 8'h34;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, borrow_out, diff_out} !== {4'b1000, W'(0)}) begin
      $display("FAIL reset: ready=%b valid=%b busy=%b borrow=%b diff=%h required 1 0 0 0 00",
               in_ready, out_valid, busy, borrow_out, diff_out);
      errors++;
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      $display("FAIL reset_idle: ready=%b busy=%b required 1 0", in_ready, busy);
      errors++;
    end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    run_op(8'd5,  8'd3,  1'b0, "5-3");
    run_op(8'd3,  8'd5,  1'b0, "3-5");
    run_op(8'h00, 8'hFF, 1'b0, "00-FF");
    run_op(8'h00, 8'h00, 1'b0, "00-00");
    run_op(8'hFF, 8'h00, 1'b0, "FF-00");
    run_op(8'h80, 8'h01, 1'b0, "80-01");
  endtask

  task automatic test_back_pressure();
    int         lat;
    logic [W:0] exp;
    exp       = {1'b0, 8'h40} - {1'b0, 8'h11};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = 8'h40;
    b_in      = 8'h11;
    @(posedge clk);
    @(negedge clk);
    // Keep a different operand pair pending for the whole hold period.
    a_in = 8'hAA;
    b_in = 8'h01;
    lat  = 0;
    while (!out_valid && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != W) begin
      $display("FAIL bp latency: got %0d cycles required %0d", lat, W);
      errors++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, busy, borrow_out, diff_out} !== {3'b101, exp}) begin
        $display("FAIL bp hold %0d: valid=%b ready=%b busy=%b borrow=%b diff=%h required 1 0 1 %b %h",
                 i, out_valid, in_ready, busy, borrow_out, diff_out, exp[W], exp[W-1:0]);
        errors++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, busy, diff_out} !== {3'b010, W'(0)}) begin
      $display("FAIL bp release: valid=%b ready=%b busy=%b diff=%h required 0 1 0 00",
               out_valid, in_ready, busy, diff_out);
      errors++;
    end
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_in      = 8'hAA;
    b_in      = 8'h55;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      $display("FAIL midop shifting: busy=%b valid=%b required 1 0", busy, out_valid);
      errors++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, borrow_out, diff_out} !== {4'b1000, W'(0)}) begin
      $display("FAIL midop reset: ready=%b valid=%b busy=%b borrow=%b diff=%h required 1 0 0 0 00",
               in_ready, out_valid, busy, borrow_out, diff_out);
      errors++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd9, 8'd2, 1'b0, "9-2 after reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b1, "random");
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    test_reset();
    test_directed();
    test_back_pressure();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
